md_unit: RTL

Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core, successor to the fixed 32-bit HI/LO unit. It accepts a decoded operation with a start strobe, latches the result, and models multi-cycle latency with separate configurable multiply and divide delays. It owns the HI/LO registers, serves mfhi/mflo reads combinationally, supports a pipeline flush that cancels an in-flight operation, and optionally supports multiply-accumulate.

---
 rtl/md_pkg.sv | 38 +++
 rtl/md_latency_ctr.sv | 33 +++
 rtl/md_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: opcode enum, default latencies,
// and op-class helpers.
package md_pkg;

  localparam int MD_OP_W            = 4;
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_t;

  // Multiply family, including the accumulate variants.
  function automatic logic is_mul(input md_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic is_mac(input md_op_t op);
    return op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic is_div(input md_op_t op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/md_latency_ctr.sv
// Busy-latency down-counter for md_unit: loads a cycle count, counts down,
// clears on flush and flags the final busy cycle with done.
module md_latency_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign busy = (cnt_q != '0);
  // A flushed final cycle must not commit its result.
  assign done = (cnt_q == CNT_W'(1)) && !flush;

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO, with configurable multi-cycle latency and flush.
// Define MD_MADD_EN to enable madd/maddu/msub/msubu; otherwise they act as MD_NONE.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2      = 2 * WIDTH;
  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] hi_q, lo_q;
  logic [W2-1:0]    result_q, result_d;
  logic             div0_q;

  logic accept, mul_ok, take_mul, take_div, take_long;
  logic ctr_busy, ctr_done;
  logic [CNT_W-1:0] lat_val;

  assign accept = start && !ctr_busy && !flush;

`ifdef MD_MADD_EN
  assign mul_ok = is_mul(op);
`else
  assign mul_ok = is_mul(op) && !is_mac(op);
`endif

  assign take_mul  = accept && mul_ok;
  assign take_div  = accept && is_div(op);
  assign take_long = take_mul || take_div;
  assign lat_val   = take_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // Datapath: full-width products and quotient/remainder pairs.
  logic [W2-1:0]    prod_s, prod_u;
  logic [WIDTH-1:0] div_b, quo_s, rem_s, quo_u, rem_u;
  logic             div_ovf;

  assign prod_s = W2'($signed(src_a)) * W2'($signed(src_b));
  assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

  // Divisor forced nonzero so the divider never sees x/0; the result is dropped anyway.
  assign div_b   = (src_b == '0) ? ONE : src_b;
  assign div_ovf = (src_a == MIN_NEG) && (src_b == '1);
  assign quo_s   = div_ovf ? MIN_NEG : WIDTH'($signed(src_a) / $signed(div_b));
  assign rem_s   = div_ovf ? '0      : WIDTH'($signed(src_a) % $signed(div_b));
  assign quo_u   = src_a / div_b;
  assign rem_u   = src_a % div_b;

`ifdef MD_MADD_EN
  logic [W2-1:0] hilo;
  assign hilo = {hi_q, lo_q};
`endif

  always_comb begin
    result_d = prod_u;
    case (op)
      MD_MULT:  result_d = prod_s;
      MD_DIV:   result_d = {rem_s, quo_s};
      MD_DIVU:  result_d = {rem_u, quo_u};
`ifdef MD_MADD_EN
      MD_MADD:  result_d = hilo + prod_s;
      MD_MADDU: result_d = hilo + prod_u;
      MD_MSUB:  result_d = hilo - prod_s;
      MD_MSUBU: result_d = hilo - prod_u;
`endif
      default:  ;
    endcase
  end

  md_latency_ctr #(
    .CNT_W (CNT_W)
  ) u_lat (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load     (take_long),
    .load_val (lat_val),
    .busy     (ctr_busy),
    .done     (ctr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      div0_q   <= 1'b0;
    end else if (!flush) begin
      if (ctr_done && !div0_q) begin
        {hi_q, lo_q} <= result_q;
      end
      if (take_long) begin
        result_q <= result_d;
        div0_q   <= take_div && (src_b == '0);
      end
      if (accept && op == MD_MTHI) hi_q <= src_a;
      if (accept && op == MD_MTLO) lo_q <= src_a;
    end
  end

  assign busy    = ctr_busy;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = (op == MD_MFHI) ? hi_q :
                   (op == MD_MFLO) ? lo_q : '0;

endmodule
